// File: rtl/tl_punch_pkg.sv
// tl_punch_pkg: shared TileLink-UL constants and width defaults for the
// punch arbiter. The A-channel opcodes, the D-channel opcodes and the fixed
// transfer size live here so every block agrees on the encoding.
package tl_punch_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;
    localparam int SRC_W_DEF  = 2;

    // A-channel opcodes
    localparam logic [2:0] TL_A_PUT_FULL = 3'd0;
    localparam logic [2:0] TL_A_GET      = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    // Every access is one full 8-byte beat (log2 bytes).
    localparam logic [3:0] TL_A_SIZE = 4'd3;
endpackage

// File: rtl/tl_punch_srctab.sv
// tl_punch_srctab: source-ID table for the punch arbiter.
// Tracks which of the 2**SRC_W source IDs are outstanding and which requester
// owns each one, and offers the lowest-numbered free ID for allocation.
// Ports:
//   clock, reset    clock / async active-high reset (all IDs free)
//   alloc_i         allocate alloc_id_o this cycle, owned by alloc_owner_i
//   d_fire_i/d_id_i D beat present and its source ID
//   avail_o         at least one ID free
//   alloc_id_o      lowest free ID (from the mask before this cycle's free)
//   hit_o           d_id_i is currently outstanding
//   hit_owner_o     requester owning d_id_i
//   any_busy_o      any ID outstanding
module tl_punch_srctab #(
    parameter int SRC_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_i,
    input  logic             alloc_owner_i,
    input  logic             d_fire_i,
    input  logic [SRC_W-1:0] d_id_i,
    output logic             avail_o,
    output logic [SRC_W-1:0] alloc_id_o,
    output logic             hit_o,
    output logic             hit_owner_o,
    output logic             any_busy_o
);
    localparam int NID = 1 << SRC_W;

    logic [NID-1:0] busy_q, busy_d;
    logic [NID-1:0] owner_q, owner_d;

    // Scan downward so the lowest free index is the last one written.
    always_comb begin
        avail_o    = 1'b0;
        alloc_id_o = '0;
        for (int i = NID - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                avail_o    = 1'b1;
                alloc_id_o = SRC_W'(i);
            end
        end
    end

    assign hit_o       = busy_q[d_id_i];
    assign hit_owner_o = owner_q[d_id_i];
    assign any_busy_o  = |busy_q;

    // The freed ID is busy and the allocated one is free, so the two
    // updates never touch the same entry.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        if (d_fire_i && hit_o) begin
            busy_d[d_id_i] = 1'b0;
        end
        if (alloc_i) begin
            busy_d[alloc_id_o]  = 1'b1;
            owner_d[alloc_id_o] = alloc_owner_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            owner_q <= '0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end
endmodule

// File: rtl/tl_punch_arbiter.sv
// tl_punch_arbiter: two-requester round-robin front end onto one TL-UL port.
// Requests are accepted into a single registered A stage, tagged with the
// lowest free source ID, and D responses are routed back to the requester
// that owns the returning ID. Stray D beats raise a sticky error flag.
// Ports:
//   clock, reset                  clock / async active-high reset
//   req_*                         per-requester request (index 0/1, packed)
//   rsp_valid/rsp_data/rsp_error  one-cycle response pulse to the owner
//   a_*                           TL-UL A channel (registered)
//   d_*                           TL-UL D channel (always ready out of reset)
//   busy                          ID outstanding or A beat pending
//   err_unexpected                sticky: D beat for a non-outstanding ID
module tl_punch_arbiter
    import tl_punch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SRC_W  = SRC_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]     req_wdata,
    input  logic [2*DATA_W/8-1:0]   req_mask,
    output logic [1:0]              rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_error,
    output logic                    a_valid,
    output logic [2:0]              a_opcode,
    output logic [2:0]              a_param,
    output logic [3:0]              a_size,
    output logic [SRC_W-1:0]        a_source,
    output logic [ADDR_W-1:0]       a_address,
    output logic [DATA_W/8-1:0]     a_mask,
    output logic [DATA_W-1:0]       a_data,
    output logic                    a_corrupt,
    input  logic                    a_ready,
    input  logic                    d_valid,
    input  logic [2:0]              d_opcode,
    input  logic [1:0]              d_param,
    input  logic [3:0]              d_size,
    input  logic [SRC_W-1:0]        d_source,
    input  logic [2:0]              d_sink,
    input  logic                    d_denied,
    input  logic [DATA_W-1:0]       d_data,
    input  logic                    d_corrupt,
    output logic                    d_ready,
    output logic                    busy,
    output logic                    err_unexpected
);
    localparam int MASK_W = DATA_W / 8;

    logic                ptr_q;
    logic                a_valid_q;
    logic [2:0]          a_opcode_q;
    logic [3:0]          a_size_q;
    logic [SRC_W-1:0]    a_source_q;
    logic [ADDR_W-1:0]   a_address_q;
    logic [MASK_W-1:0]   a_mask_q;
    logic [DATA_W-1:0]   a_data_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_error_q;
    logic                err_unexpected_q;

    logic [1:0]          grant;
    logic                slot_free, id_avail, accept, win;
    logic                d_hit, d_owner, ids_busy;
    logic [SRC_W-1:0]    alloc_id;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [MASK_W-1:0]   sel_mask;
    logic [DATA_W-1:0]   sel_data;

    // D opcode/param/size/sink carry nothing the arbiter needs.
    logic unused_d;
    assign unused_d = ^{d_opcode, d_param, d_size, d_sink};

    // The pointer only matters on contention; a lone requester always wins.
    always_comb begin
        grant = req_valid;
        if (&req_valid) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    assign slot_free = !a_valid_q || a_ready;
    assign req_ready = (reset || !slot_free || !id_avail) ? 2'b00 : grant;
    assign accept    = |(req_valid & req_ready);
    assign win       = req_ready[1];

    assign sel_write = req_write[win];
    assign sel_addr  = win ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_mask  = win ? req_mask[2*MASK_W-1:MASK_W]  : req_mask[MASK_W-1:0];
    assign sel_data  = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    tl_punch_srctab #(.SRC_W(SRC_W)) u_srctab (
        .clock         (clock),
        .reset         (reset),
        .alloc_i       (accept),
        .alloc_owner_i (win),
        .d_fire_i      (d_valid),
        .d_id_i        (d_source),
        .avail_o       (id_avail),
        .alloc_id_o    (alloc_id),
        .hit_o         (d_hit),
        .hit_owner_o   (d_owner),
        .any_busy_o    (ids_busy)
    );

    // A stage: loads on acceptance, otherwise holds until the handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q       <= 1'b0;
            a_valid_q   <= 1'b0;
            a_opcode_q  <= '0;
            a_size_q    <= '0;
            a_source_q  <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
        end else if (accept) begin
            ptr_q       <= ~win;
            a_valid_q   <= 1'b1;
            a_opcode_q  <= sel_write ? TL_A_PUT_FULL : TL_A_GET;
            a_size_q    <= TL_A_SIZE;
            a_source_q  <= alloc_id;
            a_address_q <= sel_addr;
            a_mask_q    <= sel_write ? sel_mask : {MASK_W{1'b1}};
            a_data_q    <= sel_write ? sel_data : '0;
        end else if (a_ready) begin
            a_valid_q   <= 1'b0;
        end
    end

    // Response pulse to the owner; data of stray beats is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_q      <= 2'b00;
            rsp_data_q       <= '0;
            rsp_error_q      <= 1'b0;
            err_unexpected_q <= 1'b0;
        end else begin
            rsp_valid_q <= (d_valid && d_hit) ? (d_owner ? 2'b10 : 2'b01) : 2'b00;
            if (d_valid && d_hit) begin
                rsp_data_q  <= d_data;
                rsp_error_q <= d_denied | d_corrupt;
            end
            if (d_valid && !d_hit) begin
                err_unexpected_q <= 1'b1;
            end
        end
    end

    assign a_valid        = a_valid_q;
    assign a_opcode       = a_opcode_q;
    assign a_param        = 3'd0;
    assign a_size         = a_size_q;
    assign a_source       = a_source_q;
    assign a_address      = a_address_q;
    assign a_mask         = a_mask_q;
    assign a_data         = a_data_q;
    assign a_corrupt      = 1'b0;
    assign d_ready        = !reset;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_error      = rsp_error_q;
    assign busy           = ids_busy | a_valid_q;
    assign err_unexpected = err_unexpected_q;
endmodule

// File: doc/tl_punch_arbiter.md
TL_PUNCH_ARBITER -- requirements
Module: tl_punch_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, TileLink address width.
REQ-002 SHALL have parameter DATA_W, 64, TileLink data width (mask width DATA_W/8).
REQ-003 SHALL have parameter SRC_W, 2, source-ID width (2**SRC_W outstanding IDs).
REQ-004 SHALL have ports: clock  in  1  sole clock; reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: req_valid  in  2; req_ready  out  2; req_write  in  2 (1=PutFullData, 0=Get); all indexed by requester 0/1.
REQ-006 SHALL have ports: req_addr  in  2*ADDR_W; req_wdata  in  2*DATA_W; req_mask  in  2*DATA_W/8; all packed per requester.
REQ-007 SHALL have ports: rsp_valid  out  2; rsp_data  out  DATA_W (shared); rsp_error  out  1 (shared).
REQ-008 SHALL have TL-UL A outputs: a_valid 1, a_opcode 3, a_param 3, a_size 4, a_source SRC_W, a_address ADDR_W, a_mask DATA_W/8, a_data DATA_W, a_corrupt 1; input a_ready 1.
REQ-009 SHALL have TL-UL D inputs: d_valid 1, d_opcode 3, d_param 2, d_size 4, d_source SRC_W, d_sink 3, d_denied 1, d_data DATA_W, d_corrupt 1; output d_ready 1.
REQ-010 SHALL have status outputs: busy  out  1  any ID outstanding; err_unexpected  out  1  sticky stray-response flag.

Function
REQ-011 SHALL register the A channel in a single stage; req_ready[i] = grant[i] & (!a_valid | a_ready) & free-ID-available.
REQ-012 SHALL arbitrate round-robin: priority pointer starts at requester 0 and moves to the other requester after each accepted request; a lone requester wins regardless of pointer.
REQ-013 SHALL present an accepted request (cycle N) on A in cycle N+1, and hold all A fields stable while a_valid & !a_ready.
REQ-014 SHALL drive a_opcode 0 (PutFullData) or 4 (Get), a_param 0, a_size 3, a_corrupt 0; Get uses a_mask 0xFF, a_data 0; Put uses the request's mask and data.
REQ-015 SHALL allocate the lowest-numbered free source ID at acceptance and record the owning requester for it.
REQ-016 SHALL deassert both req_ready while all 2**SRC_W IDs are outstanding.
REQ-017 SHALL drive d_ready 1 in every cycle after reset; no D backpressure.
REQ-018 SHALL, on d_valid with d_source outstanding, pulse rsp_valid[owner] for exactly one cycle (cycle M+1 for D in cycle M), with rsp_data = d_data and rsp_error = d_denied | d_corrupt.
REQ-019 SHALL free the responding ID at the end of cycle M; the ID is allocatable from cycle M+1, and same-cycle allocation uses the pre-free mask.
REQ-020 SHALL ignore the data of a D beat whose source is not outstanding, set err_unexpected, and hold it until reset.
REQ-021 SHALL handle acceptance and D completion in the same cycle independently, with no lost or duplicated IDs.
REQ-022 SHALL assert busy iff at least one ID is outstanding or a_valid is 1.

Reset
REQ-023 SHALL, on reset assertion (asynchronous, also mid-transaction), force a_valid 0, req_ready 0, rsp_valid 0, d_ready 0, busy 0, err_unexpected 0, all A fields 0, all IDs free, and the pointer to requester 0.
REQ-024 SHALL discard pre-reset outstanding transactions; post-reset D beats for them SHALL set err_unexpected.

Structure
REQ-025 SHALL take TL opcode constants (Get=4, PutFullData=0, AccessAck=0, AccessAckData=1), a_size, and width defaults from shared package tl_punch_pkg.
REQ-026 SHALL place the source table (free mask, owner bits, lowest-free encoder) in sub-module tl_punch_srctab.

Verification
REQ-027 SHALL verify: req0 Get 0x80000000, a_ready=1 -> A next cycle with opcode 4, source 0, mask 0xFF; D AccessAckData source 0 data 0x1122334455667788 -> rsp_valid[0] one cycle later with that data, rsp_error 0.
REQ-028 SHALL verify: both requesters valid for 4 cycles, D held idle -> grants 0,1,0,1 with sources 0,1,2,3; req_ready both 0 afterwards until a D frees an ID.
REQ-029 SHALL verify: a_ready=0 for 5 cycles with Put mask 0x0F -> A fields constant throughout; exactly one A handshake.
REQ-030 SHALL verify: D source 2 with d_denied=1 while 2 is outstanding, same cycle as a new acceptance -> rsp_error 1 to the owner; new request gets the lowest pre-free ID.
REQ-031 SHALL verify: D source 3 while 3 is free -> no rsp_valid, err_unexpected 1 and sticky.
REQ-032 SHALL verify: reset asserted mid-cycle with 3 IDs outstanding and a_valid 1 -> a_valid 0 immediately (without a clock edge), busy 0, source 0 allocated first after reset.
